// File: rtl/ddr_pkg.sv
// DDR command responder shared definitions.
// Timing defaults (CK cycles) and FSM state types.
package ddr_pkg;

    localparam int CL    = 11;
    localparam int CWL   = 9;
    localparam int tRCD  = 11;
    localparam int tRP   = 11;
    localparam int tRRD  = 4;
    localparam int BURST = 4;

    typedef enum logic [1:0] {
        B_IDLE,
        B_ACTIVATING,
        B_ACTIVE,
        B_PRECHARGING
    } bank_fsm_type;

    typedef enum logic [2:0] {
        D_IDLE,
        D_RD_LAT,
        D_RD_BURST,
        D_WR_LAT,
        D_WR_BURST
    } data_fsm_type;

endpackage

// File: rtl/ddr_bank_tracker.sv
// Single-bank state tracker: open/closed state, row, tRCD/tRP timer.
// Reports per-command legality; the top level keeps the sticky errors.
module ddr_bank_tracker
    import ddr_pkg::*;
#(
    parameter int P_TRCD = tRCD,
    parameter int P_TRP  = tRP
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_act,
    input  logic        i_pre,
    input  logic        i_rw,
    input  logic [14:0] i_row,
    output logic        o_open,
    output logic [14:0] o_row,
    output logic        o_rw_ok,
    output logic        o_err_act_open,
    output logic        o_err_trp,
    output logic        o_err_trcd,
    output logic        o_err_closed
);

    localparam logic [4:0] LP_TRCD = 5'(P_TRCD - 1);
    localparam logic [4:0] LP_TRP  = 5'(P_TRP - 1);

    bank_fsm_type r_state;
    bank_fsm_type w_state_nxt;
    bank_fsm_type w_eff;
    logic [4:0]   r_timer;
    logic [4:0]   w_timer_nxt;
    logic [14:0]  r_row;
    logic [14:0]  w_row_nxt;

    // Bank state, timer and row registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= B_IDLE;
            r_timer <= '0;
            r_row   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_row   <= w_row_nxt;
        end
    end

    // Resolve timer expiry first, then apply this cycle's command
    always_comb begin
        w_eff = r_state;
        if (r_timer == '0) begin
            if (r_state == B_ACTIVATING) begin
                w_eff = B_ACTIVE;
            end else if (r_state == B_PRECHARGING) begin
                w_eff = B_IDLE;
            end
        end
        w_state_nxt    = w_eff;
        w_timer_nxt    = (r_timer == '0) ? '0 : r_timer - 5'd1;
        w_row_nxt      = r_row;
        o_rw_ok        = 1'b0;
        o_err_act_open = 1'b0;
        o_err_trp      = 1'b0;
        o_err_trcd     = 1'b0;
        o_err_closed   = 1'b0;
        if (i_act) begin
            unique case (w_eff)
                B_IDLE: begin
                    w_state_nxt = B_ACTIVATING;
                    w_timer_nxt = LP_TRCD;
                    w_row_nxt   = i_row;
                end
                B_PRECHARGING: o_err_trp = 1'b1;
                default:       o_err_act_open = 1'b1;
            endcase
        end
        if (i_pre) begin
            if (w_eff == B_ACTIVE || w_eff == B_ACTIVATING) begin
                w_state_nxt = B_PRECHARGING;
                w_timer_nxt = LP_TRP;
            end
        end
        if (i_rw) begin
            unique case (w_eff)
                B_ACTIVE:     o_rw_ok = 1'b1;
                B_ACTIVATING: o_err_trcd = 1'b1;
                default:      o_err_closed = 1'b1;
            endcase
        end
    end

    assign o_open = (r_state == B_ACTIVATING) || (r_state == B_ACTIVE);
    assign o_row  = r_row;

endmodule

// File: rtl/ddr_mem_responder.sv
// DDR4-style command responder: decode, 16 bank trackers, tRRD check,
// read/write data-window FSM and sticky protocol error flags.
module ddr_mem_responder #(
    parameter int CL    = ddr_pkg::CL,
    parameter int CWL   = ddr_pkg::CWL,
    parameter int tRCD  = ddr_pkg::tRCD,
    parameter int tRP   = ddr_pkg::tRP,
    parameter int tRRD  = ddr_pkg::tRRD,
    parameter int BURST = ddr_pkg::BURST
) (
    input  logic             CK_t,
    input  logic             reset_n,
    input  logic             cs_n,
    input  logic             act_n,
    input  logic             ras_n,
    input  logic             cas_n,
    input  logic             we_n,
    input  logic [1:0]       bg_addr,
    input  logic [1:0]       ba_addr,
    input  logic [14:0]      addr,
    output logic             rd_valid,
    output logic             wr_capture,
    output logic [9:0]       rd_col,
    output logic [9:0]       wr_col,
    output logic [15:0]      bank_open,
    output logic [15:0][14:0] open_row,
    output logic [5:0]       err
);
    import ddr_pkg::*;

    localparam logic [4:0] LP_CL    = 5'(CL - 2);
    localparam logic [4:0] LP_CWL   = 5'(CWL - 2);
    localparam logic [4:0] LP_BURST = 5'(BURST - 1);
    localparam logic [4:0] LP_TRRD  = 5'(tRRD);

    logic [3:0]   w_bank;
    logic         w_act, w_pre, w_rd, w_wr;
    logic [15:0]  w_rw_ok, w_e_act_open, w_e_trp, w_e_trcd, w_e_closed;
    logic         w_bank_ok, w_rrd_viol, w_overlap, w_free, w_last;
    logic         w_rd_go, w_wr_go;
    logic [5:0]   w_err_set;
    data_fsm_type r_dstate, w_dstate_nxt;
    logic [4:0]   r_dcnt, w_dcnt_nxt;
    logic [4:0]   r_rrd;
    logic [9:0]   r_rd_col, r_wr_col;
    logic [5:0]   r_err;

    assign w_bank = {bg_addr, ba_addr};
    assign w_act  = !cs_n && !act_n;
    assign w_pre  = !cs_n && act_n && ({ras_n, cas_n, we_n} == 3'b010);
    assign w_rd   = !cs_n && act_n && ({ras_n, cas_n, we_n} == 3'b101);
    assign w_wr   = !cs_n && act_n && ({ras_n, cas_n, we_n} == 3'b100);

    for (genvar i = 0; i < 16; i++) begin : g_bank
        localparam logic [3:0] LP_ID = 4'(i);
        ddr_bank_tracker #(
            .P_TRCD(tRCD),
            .P_TRP (tRP)
        ) u_bank (
            .i_clk         (CK_t),
            .i_rst_n       (reset_n),
            .i_act         (w_act && (w_bank == LP_ID)),
            .i_pre         (w_pre && (w_bank == LP_ID)),
            .i_rw          ((w_rd || w_wr) && (w_bank == LP_ID)),
            .i_row         (addr),
            .o_open        (bank_open[i]),
            .o_row         (open_row[i]),
            .o_rw_ok       (w_rw_ok[i]),
            .o_err_act_open(w_e_act_open[i]),
            .o_err_trp     (w_e_trp[i]),
            .o_err_trcd    (w_e_trcd[i]),
            .o_err_closed  (w_e_closed[i])
        );
    end

    assign w_bank_ok  = w_rw_ok[w_bank];
    assign w_rrd_viol = w_act && (r_rrd < LP_TRRD);

    // Data FSM next state; a command in the last beat chains seamlessly
    always_comb begin
        w_dstate_nxt = r_dstate;
        w_dcnt_nxt   = (r_dcnt == '0) ? '0 : r_dcnt - 5'd1;
        w_last       = 1'b0;
        unique case (r_dstate)
            D_IDLE: ;
            D_RD_LAT: if (r_dcnt == '0) begin
                w_dstate_nxt = D_RD_BURST;
                w_dcnt_nxt   = LP_BURST;
            end
            D_RD_BURST: if (r_dcnt == '0) begin
                w_dstate_nxt = D_IDLE;
                w_last       = 1'b1;
            end
            D_WR_LAT: if (r_dcnt == '0) begin
                w_dstate_nxt = D_WR_BURST;
                w_dcnt_nxt   = LP_BURST;
            end
            D_WR_BURST: if (r_dcnt == '0) begin
                w_dstate_nxt = D_IDLE;
                w_last       = 1'b1;
            end
            default: w_dstate_nxt = D_IDLE;
        endcase
        w_free    = (r_dstate == D_IDLE) || w_last;
        w_rd_go   = w_rd && w_bank_ok && w_free;
        w_wr_go   = w_wr && w_bank_ok && w_free;
        w_overlap = (w_rd || w_wr) && w_bank_ok && !w_free;
        if (w_rd_go) begin
            w_dstate_nxt = D_RD_LAT;
            w_dcnt_nxt   = LP_CL;
        end
        if (w_wr_go) begin
            w_dstate_nxt = D_WR_LAT;
            w_dcnt_nxt   = LP_CWL;
        end
    end

    assign w_err_set = {w_overlap, |w_e_trp, |w_e_trcd,
                        w_rrd_viol, |w_e_closed, |w_e_act_open};

    // Data FSM, burst columns, tRRD counter and sticky errors
    always_ff @(posedge CK_t) begin
        if (!reset_n) begin
            r_dstate <= D_IDLE;
            r_dcnt   <= '0;
            r_rd_col <= '0;
            r_wr_col <= '0;
            r_rrd    <= 5'd31;
            r_err    <= '0;
        end else begin
            r_dstate <= w_dstate_nxt;
            r_dcnt   <= w_dcnt_nxt;
            if (w_rd_go) r_rd_col <= addr[9:0];
            if (w_wr_go) r_wr_col <= addr[9:0];
            if (w_act) begin
                r_rrd <= 5'd1;
            end else if (r_rrd != 5'd31) begin
                r_rrd <= r_rrd + 5'd1;
            end
            r_err <= r_err | w_err_set;
        end
    end

    assign rd_valid   = (r_dstate == D_RD_BURST);
    assign wr_capture = (r_dstate == D_WR_BURST);
    assign rd_col     = r_rd_col;
    assign wr_col     = r_wr_col;
    assign err        = r_err;

endmodule

// File: tb/tb_ddr_mem_responder.sv
// Bench for ddr_mem_responder: command table with per-step state checks,
// data beats checked against a queue of expected (cycle, column) records.
module tb_ddr_mem_responder;
    import ddr_pkg::*;

    logic CK_t = 1'b0;
    logic reset_n = 1'b0;
    logic cs_n = 1'b1, act_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
    logic [1:0] bg_addr = '0, ba_addr = '0;
    logic [14:0] addr = '0;
    logic rd_valid, wr_capture;
    logic [9:0] rd_col, wr_col;
    logic [15:0] bank_open;
    logic [15:0][14:0] open_row;
    logic [5:0] err;

    ddr_mem_responder dut (
        .CK_t(CK_t), .reset_n(reset_n), .cs_n(cs_n), .act_n(act_n),
        .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .bg_addr(bg_addr),
        .ba_addr(ba_addr), .addr(addr), .rd_valid(rd_valid),
        .wr_capture(wr_capture), .rd_col(rd_col), .wr_col(wr_col),
        .bank_open(bank_open), .open_row(open_row), .err(err)
    );

    always #5 CK_t = ~CK_t;

    int ecnt = 0;
    always @(posedge CK_t) ecnt <= ecnt + 1;

    typedef enum int {K_NOP, K_ACT, K_PRE, K_RD, K_WR} kind_t;
    typedef struct {
        int         cyc;
        logic [9:0] col;
    } beat_t;
    typedef struct {
        kind_t       k;
        logic [3:0]  bank;
        logic [14:0] a;
        int          gap;
        bit          push;
        logic [5:0]  e_err;
        bit          e_open;
        logic [14:0] e_row;
    } vec_t;

    beat_t rq[$];
    beat_t wq[$];
    beat_t rb, wb;
    vec_t  tbl[16];
    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // Drive one command for one edge; outputs are read 2 time units later
    task automatic cmd(input kind_t k, input logic [3:0] bank,
                       input logic [14:0] a, input bit push);
        cs_n  = (k == K_NOP);
        act_n = (k != K_ACT);
        case (k)
            K_PRE:   {ras_n, cas_n, we_n} = 3'b010;
            K_RD:    {ras_n, cas_n, we_n} = 3'b101;
            K_WR:    {ras_n, cas_n, we_n} = 3'b100;
            default: {ras_n, cas_n, we_n} = 3'b111;
        endcase
        {bg_addr, ba_addr} = bank;
        addr = a;
        @(posedge CK_t);
        #2;
        cs_n = 1'b1; act_n = 1'b1;
        {ras_n, cas_n, we_n} = 3'b111;
        if (push && k == K_RD)
            for (int j = 0; j < BURST; j++)
                rq.push_back('{ecnt + CL - 1 + j, a[9:0]});
        if (push && k == K_WR)
            for (int j = 0; j < BURST; j++)
                wq.push_back('{ecnt + CWL - 1 + j, a[9:0]});
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) cmd(K_NOP, 4'd0, 15'd0, 1'b0);
    endtask

    task automatic drain(input string nm);
        for (int t = 0; t < 60 && (rq.size() + wq.size()) > 0; t++) idle(1);
        chk({nm, " rd beats left"}, rq.size(), 0);
        chk({nm, " wr beats left"}, wq.size(), 0);
    endtask

    task automatic do_reset(input string nm);
        reset_n = 1'b0;
        idle(2);
        chk({nm, " err"}, err, 0);
        chk({nm, " bank_open"}, bank_open, 0);
        chk({nm, " open_row"}, {31'd0, |open_row}, 0);
        chk({nm, " rd_valid"}, rd_valid, 0);
        chk({nm, " wr_capture"}, wr_capture, 0);
        chk({nm, " rd_col"}, rd_col, 0);
        chk({nm, " wr_col"}, wr_col, 0);
        reset_n = 1'b1;
    endtask

    // Beat monitor: every valid beat must match the next expected record
    always @(posedge CK_t) begin
        #1;
        if (rd_valid) begin
            if (rq.size() == 0) begin
                chk("rd_valid unexpected", rd_valid, 0);
            end else begin
                rb = rq.pop_front();
                chk("rd beat cycle", ecnt, rb.cyc);
                chk("rd_col", rd_col, rb.col);
            end
        end
        if (wr_capture) begin
            if (wq.size() == 0) begin
                chk("wr_capture unexpected", wr_capture, 0);
            end else begin
                wb = wq.pop_front();
                chk("wr beat cycle", ecnt, wb.cyc);
                chk("wr_col", wr_col, wb.col);
            end
        end
    end

    initial begin
        tbl[0]  = '{K_ACT, 4'd6, 15'h1A3, 0,  1'b0, 6'h00, 1'b1, 15'h1A3};
        tbl[1]  = '{K_RD,  4'd6, 15'h040, 10, 1'b1, 6'h00, 1'b1, 15'h1A3};
        tbl[2]  = '{K_WR,  4'd6, 15'h055, 18, 1'b1, 6'h00, 1'b1, 15'h1A3};
        tbl[3]  = '{K_RD,  4'd6, 15'h077, 11, 1'b1, 6'h00, 1'b1, 15'h1A3};
        tbl[4]  = '{K_ACT, 4'd0, 15'h005, 17, 1'b0, 6'h00, 1'b1, 15'h005};
        tbl[5]  = '{K_ACT, 4'd4, 15'h009, 1,  1'b0, 6'h04, 1'b1, 15'h009};
        tbl[6]  = '{K_RD,  4'd0, 15'h001, 2,  1'b0, 6'h0C, 1'b1, 15'h005};
        tbl[7]  = '{K_RD,  4'd0, 15'h0AA, 5,  1'b1, 6'h0C, 1'b1, 15'h005};
        tbl[8]  = '{K_RD,  4'd0, 15'h002, 1,  1'b0, 6'h2C, 1'b1, 15'h005};
        tbl[9]  = '{K_ACT, 4'd0, 15'h007, 0,  1'b0, 6'h2D, 1'b1, 15'h005};
        tbl[10] = '{K_ACT, 4'd3, 15'h033, 15, 1'b0, 6'h2D, 1'b1, 15'h033};
        tbl[11] = '{K_PRE, 4'd3, 15'h000, 11, 1'b0, 6'h2D, 1'b0, 15'h033};
        tbl[12] = '{K_ACT, 4'd3, 15'h099, 5,  1'b0, 6'h3D, 1'b0, 15'h033};
        tbl[13] = '{K_ACT, 4'd3, 15'h044, 4,  1'b0, 6'h3D, 1'b1, 15'h044};
        tbl[14] = '{K_WR,  4'd9, 15'h003, 0,  1'b0, 6'h3F, 1'b0, 15'h000};
        tbl[15] = '{K_PRE, 4'd9, 15'h000, 0,  1'b0, 6'h3F, 1'b0, 15'h000};

        do_reset("reset0");
        foreach (tbl[i]) begin
            idle(tbl[i].gap);
            cmd(tbl[i].k, tbl[i].bank, tbl[i].a, tbl[i].push);
            chk($sformatf("v%0d err", i), err, tbl[i].e_err);
            chk($sformatf("v%0d bank_open", i),
                bank_open[tbl[i].bank], tbl[i].e_open);
            chk($sformatf("v%0d open_row", i),
                open_row[tbl[i].bank], tbl[i].e_row);
        end
        drain("table");

        do_reset("reset1");
        cmd(K_ACT, 4'd1, 15'h011, 1'b0);
        idle(3);
        cmd(K_ACT, 4'd5, 15'h055, 1'b0);
        chk("tRRD exact err", err, 6'h00);
        idle(5);
        cmd(K_RD, 4'd1, 15'h004, 1'b0);
        chk("tRCD-1 rd err", err, 6'h08);
        cmd(K_RD, 4'd1, 15'h005, 1'b1);
        chk("tRCD exact rd err", err, 6'h08);
        drain("boundary");

        do_reset("reset2");
        cmd(K_ACT, 4'd6, 15'h1A3, 1'b0);
        idle(10);
        cmd(K_RD, 4'd6, 15'h040, 1'b1);
        for (int t = 0; t < 30 && rq.size() > 2; t++) idle(1);
        chk("burst started", rq.size(), 2);
        reset_n = 1'b0;
        idle(1);
        chk("midburst rd_valid", rd_valid, 0);
        chk("midburst bank_open", bank_open, 0);
        chk("midburst err", err, 0);
        chk("midburst rd_col", rd_col, 0);
        rq.delete();
        reset_n = 1'b1;
        idle(20);
        drain("midburst");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/ddr_mem_responder.md
DDR_MEM_RESPONDER -- requirements
Module: ddr_mem_responder

Interface
REQ-001 Parameters (name, default, meaning), defaults taken from ddr_pkg:
  CL 11 read latency, CK cycles RD->first data beat.
  CWL 9 write latency, CK cycles WR->first data beat.
  tRCD 11 minimum ACT->RD/WR, same bank.
  tRP 11 minimum PRE->ACT, same bank.
  tRRD 4 minimum ACT->ACT, any bank.
  BURST 4 data-valid cycles per RD/WR (BL8, DDR).
REQ-002 Ports (name, direction, width, meaning); the clock and reset ports are named as the DDR interface names them; one clock; reset is synchronous and active-low:
  CK_t  in  1  clock, all logic on rising edge.
  reset_n  in  1  synchronous active-low reset.
  cs_n, act_n, ras_n, cas_n, we_n  in  1 each  command pins.
  bg_addr  in  2  bank group.
  ba_addr  in  2  bank.
  addr  in  15  row (ACT) or column in bits [9:0] (RD/WR).
  rd_valid  out  1  read data beat window.
  wr_capture  out  1  write data capture window.
  rd_col, wr_col  out  10  column of the active burst.
  bank_open  out  16  per-bank open flag, index {bg_addr,ba_addr}.
  open_row  out  16x15  row held by each bank.
  err  out  6  sticky violations [act_open, cmd_closed, trrd, trcd, trp, overlap].

Function
REQ-003 Decode on CK_t when cs_n=0: act_n=0 -> ACT. Otherwise, with act_n=1: ras/cas/we = 0,1,0 -> PRE; 1,0,1 -> RD; 1,0,0 -> WR. All other encodings, and cs_n=1, are NOP.
REQ-004 Each bank has states B_IDLE, B_ACTIVATING, B_ACTIVE, B_PRECHARGING, plus a 5-bit timer.
REQ-005 ACT in B_IDLE -> B_ACTIVATING: latch row, set bank_open, load timer with tRCD-1. The bank enters B_ACTIVE when the timer reaches 0.
REQ-006 ACT to a bank not in B_IDLE sets err[0]; bank state and stored row are unchanged.
REQ-007 ACT issued fewer than tRRD cycles after the previous ACT (any bank) sets err[2]; the ACT is still executed.
REQ-008 PRE to B_ACTIVE or B_ACTIVATING -> B_PRECHARGING: clear bank_open, load timer with tRP-1, then -> B_IDLE. PRE to B_IDLE is a legal NOP. PRE to B_PRECHARGING is ignored.
REQ-009 ACT to a bank in B_PRECHARGING sets err[4] (tRP) and is ignored.
REQ-010 RD/WR to a bank in B_ACTIVATING sets err[3] and is ignored. RD/WR to B_IDLE or B_PRECHARGING sets err[1] and is ignored.
REQ-011 Data FSM states: D_IDLE, D_RD_LAT, D_RD_BURST, D_WR_LAT, D_WR_BURST.
  Legal RD at cycle N: rd_valid=1 for cycles N+CL through N+CL+BURST-1.
  Legal WR at cycle N: wr_capture=1 for cycles N+CWL through N+CWL+BURST-1.
  rd_col/wr_col hold the column for the whole window.
REQ-012 RD/WR accepted while the data FSM is not in D_IDLE sets err[5] and is ignored. Exception: a command in the final burst cycle is accepted (seamless back-to-back).
REQ-013 Simultaneous timer expiry and new command in the same cycle: expiry is evaluated first.
REQ-014 err bits are sticky until reset. The tRRD counter saturates at 31.

Reset
REQ-015 reset_n=0 sampled at a CK_t edge forces:
  all banks to B_IDLE, bank_open=0, open_row=0;
  data FSM to D_IDLE, rd_valid=0, wr_capture=0, rd_col=0, wr_col=0;
  err=0;
  tRRD counter to saturated, so the first ACT is legal.
REQ-016 Reset asserted mid-burst takes effect on that edge; no further data beats are produced.

Structure
REQ-017 ddr_pkg holds CL, CWL, tRCD, tRP, tRRD, BURST, bank_fsm_type and data_fsm_type.
REQ-018 Per-bank logic is one sub-module, ddr_bank_tracker, instantiated 16 times. Command decode, tRRD tracking and the data FSM are in the top level.

Verification
REQ-019 ACT bg=1,ba=2,row=0x1A3 at cycle 0 -> bank_open[6]=1 and open_row[6]=0x1A3 from cycle 1; RD col=0x040 at cycle 11 -> rd_valid on cycles 22-25 with rd_col=0x040; err=0.
REQ-020 ACT bank 0 at cycle 0, RD bank 0 at cycle 5 -> err[3]=1 and rd_valid stays 0.
REQ-021 ACT bank 0 at cycle 0, ACT bank 4 at cycle 2 -> err[2]=1 and both banks open.
REQ-022 ACT bank 3, PRE bank 3 at cycle 12, ACT bank 3 at cycle 18 -> err[4]=1; a further ACT at cycle 23 succeeds.
REQ-023 WR at cycle N, RD at cycle N+CWL+3 (last write beat) -> err=0; wr_capture on N+9..N+12, rd_valid on N+23..N+26.
REQ-024 Reset asserted during rd_valid -> rd_valid=0 on the next edge; bank_open=0 and err=0 afterwards.
